// File: rtl/shift_reg_stream.sv
// Stream-handshaked, runtime-programmable delay line: each output beat is the input
// beat accepted D beats earlier; lines fill at start and drain held samples at end.
module shift_reg_stream #(
  parameter int WIDTH = 16,
  parameter int LANES = 1,
  parameter int DEPTH = 8,
  parameter int ADDRW = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic [ADDRW-1:0]         delay_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [LANES*WIDTH-1:0]   s_data_i,
  input  logic                     s_last_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [LANES*WIDTH-1:0]   m_data_o,
  output logic                     m_last_o,
  output logic [ADDRW-1:0]         fill_o,
  output logic                     busy_o
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRW-1:0] DEPTH_A = ADDRW'(DEPTH);
  localparam logic [ADDRW-1:0] ONE_A   = ADDRW'(1);
  localparam logic [ADDRW-1:0] ZERO_A  = {ADDRW{1'b0}};

  typedef enum logic [1:0] {ST_FILL = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRW-1:0]         r_fill, w_fill_nxt;
  logic [ADDRW-1:0]         r_cnt, w_cnt_nxt;
  logic [ADDRW-1:0]         r_delay_q;
  logic [ADDRW-1:0]         w_delay_sat, w_delay_eff, w_sel;
  logic [IDXW-1:0]          w_idx;
  logic                     w_latch, w_shift, w_s_ready, w_m_valid, w_m_last, w_pass;
  logic [LANES*WIDTH-1:0]   r_shreg [DEPTH];

  // Next-state, handshake and read-select logic for the FILL/RUN/DRAIN controller
  always_comb begin
    // At line start the fresh delay is used in the same cycle it is latched
    w_latch     = (r_state == ST_FILL) && (r_fill == ZERO_A);
    w_delay_sat = (delay_i > DEPTH_A) ? DEPTH_A : delay_i;
    w_delay_eff = w_latch ? w_delay_sat : r_delay_q;
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_s_ready   = 1'b0;
    w_m_valid   = 1'b0;
    w_m_last    = 1'b0;
    w_sel       = ZERO_A;
    case (r_state)
      ST_FILL: begin
        if (w_delay_eff == ZERO_A) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_s_ready = 1'b1;
          if (s_valid_i) begin
            w_shift    = 1'b1;
            w_fill_nxt = r_fill + ONE_A;
            if (s_last_i) begin
              w_state_nxt = ST_DRAIN;
              w_cnt_nxt   = r_fill + ONE_A;
            end else if ((r_fill + ONE_A) == w_delay_eff) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_FILL;
            end
          end else begin
            w_shift = 1'b0;
          end
        end
      end
      ST_RUN: begin
        w_m_valid = s_valid_i;
        w_s_ready = m_ready_i;
        w_sel     = r_delay_q - ONE_A;
        w_m_last  = (r_delay_q == ZERO_A) ? s_last_i : 1'b0;
        if (s_valid_i && m_ready_i) begin
          w_shift = 1'b1;
          if (s_last_i) begin
            if (r_delay_q == ZERO_A) begin
              w_state_nxt = ST_FILL;
            end else begin
              w_state_nxt = ST_DRAIN;
              w_cnt_nxt   = r_delay_q;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_shift = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_m_valid = 1'b1;
        w_sel     = r_cnt - ONE_A;
        w_m_last  = (r_cnt == ONE_A);
        if (m_ready_i) begin
          if (r_cnt == ONE_A) begin
            w_state_nxt = ST_FILL;
            w_fill_nxt  = ZERO_A;
            w_cnt_nxt   = ZERO_A;
          end else begin
            w_fill_nxt = r_fill - ONE_A;
            w_cnt_nxt  = r_cnt - ONE_A;
          end
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_fill_nxt  = ZERO_A;
        w_cnt_nxt   = ZERO_A;
      end
    endcase
  end

  assign w_idx     = w_sel[IDXW-1:0];
  assign w_pass    = (r_state == ST_RUN) && (r_delay_q == ZERO_A);
  assign s_ready_o = w_s_ready & ~clear_i;
  assign m_valid_o = w_m_valid & ~clear_i;
  assign m_last_o  = w_m_last & ~clear_i;
  assign m_data_o  = w_pass ? s_data_i : r_shreg[w_idx];
  assign fill_o    = r_fill;
  assign busy_o    = (r_state != ST_FILL) || (r_fill != ZERO_A);

  // Control state registers; clear aborts the line back to an empty FILL
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_FILL;
      r_fill    <= ZERO_A;
      r_cnt     <= ZERO_A;
      r_delay_q <= ZERO_A;
    end else begin
      r_delay_q <= w_delay_eff;
      if (clear_i) begin
        r_state <= ST_FILL;
        r_fill  <= ZERO_A;
        r_cnt   <= ZERO_A;
      end else begin
        r_state <= w_state_nxt;
        r_fill  <= w_fill_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

  // Sample storage, newest at index 0; deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_shift && !clear_i) begin
      r_shreg[0] <= s_data_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_shreg[k] <= r_shreg[k-1];
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_stream.sv
// Scoreboard bench for shift_reg_stream: accepted beats are queued as expectations
// and popped/compared as the DUT emits output beats.
module tb_shift_reg_stream;

  logic        clk_i = 1'b0;
  logic        rstn_i, clear_i;
  logic [3:0]  delay_i;
  logic        s_valid_i, s_ready_o, s_last_i;
  logic [15:0] s_data_i;
  logic        m_valid_o, m_ready_i, m_last_o;
  logic [15:0] m_data_o;
  logic [3:0]  fill_o;
  logic        busy_o;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_out = 0;
  int          ready_pct = 100;
  bit          pt_chk = 1'b0;
  logic [16:0] q [$];

  shift_reg_stream #(.WIDTH(16), .LANES(1), .DEPTH(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i), .delay_i(delay_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .fill_o(fill_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat
  task automatic send_beat(input logic [15:0] d, input logic last);
    bit acc;
    int k;
    acc = 1'b0;
    k = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    while (!acc && k < 300) begin
      @(negedge clk_i);
      acc = s_ready_o;
      @(posedge clk_i);
      #1;
      k++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_o || q.size() != 0) && k < 400) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    chk("idle_timeout", 32'(k < 400), 32'd1);
  endtask

  initial begin
    int base;
    rstn_i = 1'b0; clear_i = 1'b0; delay_i = 4'd3;
    s_valid_i = 1'b0; s_data_i = 16'd0; s_last_i = 1'b0; m_ready_i = 1'b1;

    fork
      // output monitor and scoreboard
      begin
        bit          stall_r;
        logic [16:0] stall_v, exp;
        stall_r = 1'b0;
        stall_v = 17'd0;
        forever begin
          @(negedge clk_i);
          if (!rstn_i || clear_i) begin
            q.delete();
            stall_r = 1'b0;
          end else begin
            if (stall_r) begin
              chk("stall_valid", 32'(m_valid_o), 32'd1);
              chk("stall_data", 32'({m_last_o, m_data_o}), 32'(stall_v));
            end
            if (s_valid_i && s_ready_o) begin
              q.push_back({s_last_i, s_data_i});
              if (pt_chk) begin
                chk("pt_data", 32'(m_data_o), 32'(s_data_i));
                chk("pt_last", 32'(m_last_o), 32'(s_last_i));
                chk("pt_fill", 32'(fill_o), 32'd0);
              end
            end
            if (m_valid_o && m_ready_i) begin
              n_out++;
              if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
              end else begin
                exp = q.pop_front();
                chk("out_data", 32'(m_data_o), 32'(exp[15:0]));
                chk("out_last", 32'(m_last_o), 32'(exp[16]));
              end
            end
            stall_r = m_valid_o && !m_ready_i;
            stall_v = {m_last_o, m_data_o};
          end
        end
      end
      // downstream ready generator
      forever begin
        @(posedge clk_i);
        #1;
        m_ready_i = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      end
    join_none

    // reset values
    #12;
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_m_last", 32'(m_last_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_s_ready", 32'(s_ready_o), 32'd1);
    chk("rst_fill", 32'(fill_o), 32'd0);
    clear_i = 1'b1;
    #1 chk("rst_clear_ready", 32'(s_ready_o), 32'd0);
    clear_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    #1;
    chk("rel_s_ready", 32'(s_ready_o), 32'd1);
    chk("rel_busy", 32'(busy_o), 32'd0);

    // basic delay D=3, line 0..9
    base = n_out;
    for (int i = 0; i < 3; i++) send_beat(16'(i), 1'b0);
    chk("d3_no_out", 32'(n_out - base), 32'd0);
    chk("d3_fill", 32'(fill_o), 32'd3);
    send_beat(16'd3, 1'b0);
    chk("d3_first_out", 32'(n_out - base), 32'd1);
    for (int i = 4; i < 9; i++) send_beat(16'(i), 1'b0);
    send_beat(16'd9, 1'b1);
    chk("d3_before_drain", 32'(n_out - base), 32'd7);
    wait_idle();
    chk("d3_count", 32'(n_out - base), 32'd10);
    chk("d3_fill_end", 32'(fill_o), 32'd0);

    // D=0 pass-through
    delay_i = 4'd0;
    pt_chk = 1'b1;
    base = n_out;
    for (int i = 0; i < 5; i++) send_beat(16'h100 + 16'(i), i == 4);
    pt_chk = 1'b0;
    delay_i = 4'd5;
    chk("d0_count", 32'(n_out - base), 32'd5);
    wait_idle();

    // short line, D=5
    base = n_out;
    send_beat(16'h000A, 1'b0);
    send_beat(16'h000B, 1'b1);
    @(negedge clk_i); chk("short_ready_1", 32'(s_ready_o), 32'd0);
    @(negedge clk_i); chk("short_ready_2", 32'(s_ready_o), 32'd0);
    @(negedge clk_i); chk("short_ready_3", 32'(s_ready_o), 32'd1);
    #1 chk("short_count", 32'(n_out - base), 32'd2);
    @(posedge clk_i); #1;
    wait_idle();

    // backpressure, D=2
    delay_i = 4'd2;
    ready_pct = 50;
    base = n_out;
    for (int i = 0; i < 100; i++) send_beat(16'($urandom), i == 99);
    wait_idle();
    chk("bp_count", 32'(n_out - base), 32'd100);
    ready_pct = 100;

    // saturation (15 -> 8) and mid-line retiming request
    delay_i = 4'd15;
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      send_beat(16'h200 + 16'(i), 1'b0);
      if (i == 3) delay_i = 4'd1;
    end
    chk("sat_no_out", 32'(n_out - base), 32'd0);
    chk("sat_fill", 32'(fill_o), 32'd8);
    send_beat(16'h208, 1'b0);
    chk("sat_first_out", 32'(n_out - base), 32'd1);
    for (int i = 9; i < 12; i++) send_beat(16'h200 + 16'(i), i == 11);
    wait_idle();
    chk("sat_count", 32'(n_out - base), 32'd12);
    base = n_out;
    send_beat(16'h300, 1'b0);
    chk("rt_no_out", 32'(n_out - base), 32'd0);
    chk("rt_fill", 32'(fill_o), 32'd1);
    send_beat(16'h301, 1'b0);
    chk("rt_first_out", 32'(n_out - base), 32'd1);
    send_beat(16'h302, 1'b1);
    wait_idle();
    chk("rt_count", 32'(n_out - base), 32'd3);

    // clear mid-DRAIN
    delay_i = 4'd4;
    ready_pct = 0;
    repeat (2) @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) send_beat(16'h400 + 16'(i), i == 2);
    chk("clr_valid_before", 32'(m_valid_o), 32'd1);
    clear_i = 1'b1;
    #1;
    chk("clr_valid", 32'(m_valid_o), 32'd0);
    chk("clr_ready", 32'(s_ready_o), 32'd0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    chk("clr_fill", 32'(fill_o), 32'd0);
    chk("clr_busy", 32'(busy_o), 32'd0);
    ready_pct = 100;
    base = n_out;
    for (int i = 0; i < 6; i++) send_beat(16'h410 + 16'(i), i == 5);
    wait_idle();
    chk("clr_next_count", 32'(n_out - base), 32'd6);

    // reset mid-RUN
    delay_i = 4'd2;
    for (int i = 0; i < 5; i++) send_beat(16'h500 + 16'(i), 1'b0);
    chk("rr_busy_before", 32'(busy_o), 32'd1);
    s_valid_i = 1'b1;
    s_data_i  = 16'h5FF;
    rstn_i = 1'b0;
    #1;
    chk("rr_fill", 32'(fill_o), 32'd0);
    chk("rr_busy", 32'(busy_o), 32'd0);
    chk("rr_m_valid", 32'(m_valid_o), 32'd0);
    chk("rr_m_last", 32'(m_last_o), 32'd0);
    chk("rr_s_ready", 32'(s_ready_o), 32'd1);
    s_valid_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    delay_i = 4'd2;
    base = n_out;
    for (int i = 0; i < 4; i++) send_beat(16'h600 + 16'(i), i == 3);
    wait_idle();
    chk("rr_next_count", 32'(n_out - base), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_reg_stream.md
# shift_reg_stream

Stream-handshaked, runtime-programmable delay line for the DWT lifting datapath. It is a multi-lane shift register with a valid/ready interface on both sides. Each output beat is the input beat accepted D beats earlier. The block fills at line start and drains the held samples at line end, so every line emits exactly as many beats as it accepts, in order.

## Interface
- Width, 16: bits per lane sample.
- Lanes, 1: parallel lanes; all lanes share control and shift together.
- Depth, 8: maximum delay D, at least 1.
- AddrW, $clog2(Depth+1): width of delay and fill fields (derived).

- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous abort; return to empty FILL.
- delay_i  in  AddrW  requested delay D; values above Depth saturate to Depth.
- s_valid_i  in  1  input beat valid.
- s_ready_o  out  1  input beat accepted when s_valid_i and s_ready_o are both high.
- s_data_i  in  Lanes*Width  input samples; lane n occupies bits [n*Width +: Width].
- s_last_i  in  1  last beat of line.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  output beat consumed when m_valid_o and m_ready_i are both high.
- m_data_o  out  Lanes*Width  delayed samples.
- m_last_o  out  1  last output beat of line.
- fill_o  out  AddrW  number of samples currently held.
- busy_o  out  1  high when state ≠ FILL or fill_o ≠ 0.

## Operation
- Storage: shreg[0..Depth-1] per lane, with shreg[0] the newest sample. Each accepted input shifts shreg[k] into shreg[k+1] and loads s_data_i into shreg[0]. Data registers have no reset.
- delay_q latches the saturated delay_i on every cycle in which state = FILL and fill = 0. It is held at all other times.
- States: FILL, RUN, DRAIN. A drain counter cnt runs from 1 to Depth.
- FILL:
  - s_ready_o = 1, m_valid_o = 0.
  - On each accept, fill increments.
  - Accept with s_last_i = 1: go to DRAIN with cnt = fill+1.
  - Accept with no last where fill+1 = delay_q: go to RUN.
  - If delay_q = 0, go to RUN directly without accepting.
- RUN:
  - m_valid_o = s_valid_i; s_ready_o = m_ready_i.
  - m_data_o = shreg[delay_q-1], or s_data_i when delay_q = 0.
  - m_last_o = s_last_i when delay_q = 0, otherwise 0.
  - Each transfer shifts the register; fill stays at delay_q.
  - Transfer with s_last_i = 1:
    - delay_q = 0: go to FILL.
    - delay_q > 0: go to DRAIN with cnt = delay_q.
- DRAIN:
  - s_ready_o = 0, m_valid_o = 1.
  - m_data_o = shreg[cnt-1]; m_last_o = (cnt = 1).
  - On each transfer, cnt and fill decrement; no shift occurs.
  - Transfer with cnt = 1: go to FILL with fill = 0.
- clear_i has the highest priority:
  - Next state is FILL with fill = 0 and cnt = 0.
  - While clear_i is high, s_ready_o and m_valid_o are forced to 0 combinationally.
  - Any beat in flight is dropped, including mid-DRAIN.
- Changing delay_i mid-line has no effect until the next line start.

## Timing
- Reset (rstn_i low, asynchronous): state = FILL, fill_o = 0, delay_q = 0, cnt = 0.
- Outputs while in reset and just after release: m_valid_o = 0, m_last_o = 0, busy_o = 0, s_ready_o = 1.
  - Exception: while clear_i is high, s_ready_o = 0.
- RUN is zero-latency pass-through. Both s_valid_i→m_valid_o and m_ready_i→s_ready_o are combinational paths. The output beat leaves in the same cycle the paired input is accepted.
- Sustained throughput is 1 beat/cycle in RUN and DRAIN. FILL outputs nothing for delay_q accepted beats.
- Per line: output beats = input beats, order preserved. A line with L < D beats produces its L outputs during DRAIN.
- Once asserted, m_valid_o does not drop without a transfer, except on clear_i.
- m_data_o and m_last_o are stable while m_valid_o = 1 and m_ready_i = 0.
- The next line's first beat can be accepted in the cycle after the final DRAIN transfer.

## Test plan
- Basic delay: Depth = 8, D = 3, line 0..9 with m_ready_i held high.
  - No outputs for 3 beats.
  - Outputs 0..9 in order; beats 7, 8, 9 come out in DRAIN.
  - m_last_o is high only on 9; fill_o ends at 0.
- D = 0 pass-through: s_data_i appears on m_data_o in the same cycle.
  - s_last_i maps to m_last_o in the same cycle; fill_o stays 0.
- Short line: D = 5, line of 2 beats (0xA, 0xB) with s_last_i on 0xB.
  - Outputs 0xA, then 0xB with m_last_o.
  - s_ready_o stays 0 until both outputs are taken.
- Backpressure: D = 2, random m_ready_i at 50% over 100 beats.
  - Output equals the input sequence exactly.
  - Data is stable while stalled; no beat is lost or duplicated.
- Delay saturation and retiming:
  - delay_i = 15 with Depth = 8 behaves as D = 8.
  - Changing delay_i to 1 mid-line takes effect only on the next line.
- Abort cases:
  - clear_i mid-DRAIN: m_valid_o = 0 in the same cycle, fill_o = 0 next cycle, next line behaves cleanly.
  - rstn_i asserted mid-RUN: all state returns to reset values immediately.
